// File: rtl/sysbus_arb_pkg.sv
// Shared types and constants for the two-client Sysbus arbiter.
// Transaction shape: writes are 1 address + 8 data beats; reads return 8 response beats.
package sysbus_arb_pkg;

   localparam int unsigned BUS_DW     = 64;
   localparam int unsigned BUS_TW     = 13;
   localparam int unsigned TAG_RW_BIT = BUS_TW - 1;
   localparam int unsigned WR_BEATS   = 9;
   localparam int unsigned RD_BEATS   = 8;
   localparam int unsigned CNT_W      = 4;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_REQ,
      ARB_RESP
   } arb_state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: with both requesting, the client that did not win last time wins.
module arb_rr2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant_idx,
   output logic       valid
);

   always_comb begin
      valid     = |req;
      grant_idx = 1'b0;
      case (req)
         2'b01:   grant_idx = 1'b0;
         2'b10:   grant_idx = 1'b1;
         2'b11:   grant_idx = ~last_grant;
         default: grant_idx = 1'b0;
      endcase
   end

endmodule

// File: rtl/sysbus_arbiter.sv
// Arbitrates fetch (client 0) and memory (client 1) onto the single Sysbus port, one whole
// transaction at a time, and steers the response burst back to the owning client.
module sysbus_arbiter
   import sysbus_arb_pkg::*;
#(
   parameter int unsigned BUS_DATA_WIDTH = BUS_DW,
   parameter int unsigned BUS_TAG_WIDTH  = BUS_TW
) (
   input  logic                      clk,
   input  logic                      reset,

   input  logic                      c0_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] c0_req,
   input  logic [BUS_TAG_WIDTH-1:0]  c0_reqtag,
   output logic                      c0_reqack,
   output logic                      c0_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] c0_resp,
   output logic [BUS_TAG_WIDTH-1:0]  c0_resptag,
   input  logic                      c0_respack,

   input  logic                      c1_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] c1_req,
   input  logic [BUS_TAG_WIDTH-1:0]  c1_reqtag,
   output logic                      c1_reqack,
   output logic                      c1_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] c1_resp,
   output logic [BUS_TAG_WIDTH-1:0]  c1_resptag,
   input  logic                      c1_respack,

   output logic                      bus_reqcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_req,
   output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   input  logic                      bus_reqack,
   input  logic                      bus_respcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   output logic                      bus_respack,

   output logic                      stray_resp
);

   arb_state_t         state_q, state_d;
   logic               owner_q, owner_d;
   logic               last_grant_q, last_grant_d;
   logic               rw_q, rw_d;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0]   resp_cnt_q, resp_cnt_d;

   logic               pick_idx;
   logic               pick_valid;

   logic                      own_reqcyc;
   logic [BUS_DATA_WIDTH-1:0] own_req;
   logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
   logic                      own_respack;
   logic                      req_fire;
   logic                      resp_fire;
   logic                      beat_rw;

   arb_rr2 u_rr2 (
      .req        ({c1_reqcyc, c0_reqcyc}),
      .last_grant (last_grant_q),
      .grant_idx  (pick_idx),
      .valid      (pick_valid)
   );

   assign own_reqcyc  = owner_q ? c1_reqcyc  : c0_reqcyc;
   assign own_req     = owner_q ? c1_req     : c0_req;
   assign own_reqtag  = owner_q ? c1_reqtag  : c0_reqtag;
   assign own_respack = owner_q ? c1_respack : c0_respack;

   assign req_fire  = bus_reqcyc & bus_reqack;
   assign resp_fire = bus_respcyc & bus_respack;

   // The direction comes from the live tag until the first beat is taken, then from rw_q.
   assign beat_rw = (beat_cnt_q == '0) ? own_reqtag[TAG_RW_BIT] : rw_q;

   // Response payload is broadcast; only respcyc is steered.
   assign c0_resp    = bus_resp;
   assign c0_resptag = bus_resptag;
   assign c1_resp    = bus_resp;
   assign c1_resptag = bus_resptag;

   // Gated by reset so every output reads 0 while reset is held, even with the bus active.
   assign stray_resp = reset & bus_respcyc & (state_q != ARB_RESP);

   always_comb begin
      bus_reqcyc  = 1'b0;
      bus_req     = '0;
      bus_reqtag  = '0;
      c0_reqack   = 1'b0;
      c1_reqack   = 1'b0;
      c0_respcyc  = 1'b0;
      c1_respcyc  = 1'b0;
      bus_respack = 1'b0;
      unique case (state_q)
         ARB_REQ: begin
            bus_reqcyc = own_reqcyc;
            bus_req    = own_req;
            bus_reqtag = own_reqtag;
            c0_reqack  = ~owner_q & bus_reqack;
            c1_reqack  = owner_q & bus_reqack;
         end
         ARB_RESP: begin
            c0_respcyc  = ~owner_q & bus_respcyc;
            c1_respcyc  = owner_q & bus_respcyc;
            bus_respack = own_respack;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      rw_d         = rw_q;
      beat_cnt_d   = beat_cnt_q;
      resp_cnt_d   = resp_cnt_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               owner_d      = pick_idx;
               last_grant_d = pick_idx;
               state_d      = ARB_REQ;
            end
         end
         ARB_REQ: begin
            if (req_fire) begin
               if (beat_cnt_q == '0) begin
                  rw_d = own_reqtag[TAG_RW_BIT];
               end
               if (!beat_rw) begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
                  state_d    = ARB_RESP;
               end else if (beat_cnt_q == CNT_W'(WR_BEATS - 1)) begin
                  state_d = ARB_IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end else if ((beat_cnt_q == '0) && !own_reqcyc) begin
               // Owner withdrew before anything was accepted: abandon the grant.
               state_d = ARB_IDLE;
            end
         end
         ARB_RESP: begin
            if (resp_fire) begin
               if (resp_cnt_q == CNT_W'(RD_BEATS - 1)) begin
                  state_d = ARB_IDLE;
               end else begin
                  resp_cnt_d = resp_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
      if (state_d == ARB_IDLE) begin
         beat_cnt_d = '0;
         resp_cnt_d = '0;
         rw_d       = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ARB_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         rw_q         <= 1'b0;
         beat_cnt_q   <= '0;
         resp_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         rw_q         <= rw_d;
         beat_cnt_q   <= beat_cnt_d;
         resp_cnt_q   <= resp_cnt_d;
      end
   end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Scoreboard bench for sysbus_arbiter: stimulus queues expected bus beats and response
// beats, a negedge monitor pops and compares them as the handshakes occur.
module tb_sysbus_arbiter;
   import sysbus_arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        c0_reqcyc = 1'b0, c1_reqcyc = 1'b0;
   logic [63:0] c0_req = '0, c1_req = '0;
   logic [12:0] c0_reqtag = '0, c1_reqtag = '0;
   logic        c0_reqack, c1_reqack, c0_respcyc, c1_respcyc;
   logic [63:0] c0_resp, c1_resp;
   logic [12:0] c0_resptag, c1_resptag;
   logic        c0_respack = 1'b0, c1_respack = 1'b0;
   logic        bus_reqcyc;
   logic [63:0] bus_req;
   logic [12:0] bus_reqtag;
   logic        bus_reqack = 1'b0;
   logic        bus_respcyc = 1'b0;
   logic [63:0] bus_resp = '0;
   logic [12:0] bus_resptag = '0;
   logic        bus_respack;
   logic        stray_resp;

   typedef struct {
      int          c;
      logic [63:0] d;
      logic [12:0] t;
   } beat_t;

   beat_t req_q[$];
   beat_t resp_q[$];
   beat_t req_e, resp_e;

   int n_tests = 0;
   int n_fail  = 0;
   bit in_write = 0, c0_ack_seen = 0, resp_seen = 0;
   int gaps[9] = '{0, 2, 0, 1, 3, 0, 0, 1, 0};

   sysbus_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .c0_reqcyc   (c0_reqcyc),
      .c0_req      (c0_req),
      .c0_reqtag   (c0_reqtag),
      .c0_reqack   (c0_reqack),
      .c0_respcyc  (c0_respcyc),
      .c0_resp     (c0_resp),
      .c0_resptag  (c0_resptag),
      .c0_respack  (c0_respack),
      .c1_reqcyc   (c1_reqcyc),
      .c1_req      (c1_req),
      .c1_reqtag   (c1_reqtag),
      .c1_reqack   (c1_reqack),
      .c1_respcyc  (c1_respcyc),
      .c1_resp     (c1_resp),
      .c1_resptag  (c1_resptag),
      .c1_respack  (c1_respack),
      .bus_reqcyc  (bus_reqcyc),
      .bus_req     (bus_req),
      .bus_reqtag  (bus_reqtag),
      .bus_reqack  (bus_reqack),
      .bus_respcyc (bus_respcyc),
      .bus_resp    (bus_resp),
      .bus_resptag (bus_resptag),
      .bus_respack (bus_respack),
      .stray_resp  (stray_resp)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input bit ok, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit outs_zero();
      return !(bus_reqcyc || (bus_req != '0) || (bus_reqtag != '0) || c0_reqack || c1_reqack
               || c0_respcyc || c1_respcyc || bus_respack || stray_resp);
   endfunction

   // Monitor: every accepted request/response beat must match the next queued expectation.
   always @(negedge clk) begin
      if (bus_reqcyc && bus_reqack) begin
         if (req_q.size() == 0) begin
            check("req_unexpected", 1'b0, bus_req, 64'h0);
         end else begin
            req_e = req_q.pop_front();
            check("req_beat", (bus_req == req_e.d) && (bus_reqtag == req_e.t), bus_req, req_e.d);
            check("req_owner", (c0_reqack == (req_e.c == 0)) && (c1_reqack == (req_e.c == 1)),
                  {c1_reqack, c0_reqack}, (req_e.c == 0) ? 64'h1 : 64'h2);
         end
      end
      if (bus_respcyc && bus_respack) begin
         if (resp_q.size() == 0) begin
            check("resp_unexpected", 1'b0, bus_resp, 64'h0);
         end else begin
            resp_e = resp_q.pop_front();
            check("resp_steer", (c0_respcyc == (resp_e.c == 0)) && (c1_respcyc == (resp_e.c == 1)),
                  {c1_respcyc, c0_respcyc}, (resp_e.c == 0) ? 64'h1 : 64'h2);
            check("resp_data", (c0_resp == resp_e.d) && (c1_resp == resp_e.d)
                  && (c0_resptag == resp_e.t) && (c1_resptag == resp_e.t),
                  (resp_e.c == 0) ? c0_resp : c1_resp, resp_e.d);
         end
      end
      if (in_write) begin
         if (c0_reqack) c0_ack_seen = 1'b1;
         if (dut.state_q == ARB_RESP) resp_seen = 1'b1;
      end
   end

   task automatic drive_client(input int c, input logic cyc, input logic [63:0] d,
                               input logic [12:0] t);
      if (c == 0) begin
         c0_reqcyc = cyc; c0_req = d; c0_reqtag = t;
      end else begin
         c1_reqcyc = cyc; c1_req = d; c1_reqtag = t;
      end
   endtask

   // Present one beat and hold it until the bus takes it; bus_reqack low for 'gap' cycles.
   task automatic send_beat(input int c, input logic [63:0] d, input logic [12:0] t,
                            input int gap);
      bit done = 1'b0;
      drive_client(c, 1'b1, d, t);
      req_q.push_back('{c, d, t});
      for (int n = 0; n < 200 && !done; n++) begin
         bus_reqack = (n >= gap);
         @(negedge clk);
         done = bus_reqcyc && bus_reqack;
         @(posedge clk);
         #1;
      end
      bus_reqack = 1'b0;
      if (!done) check("req_timeout", 1'b0, 64'h0, 64'h1);
   endtask

   // Return a read burst of 8 beats; optionally stall the owner's respack, or stop at a beat.
   task automatic serve_resp(input int c, input logic [63:0] base, input int stall_at,
                             input int stall_len, input int abort_at);
      bit done;
      bit stall;
      for (int i = 0; i < 8; i++) begin
         bus_respcyc = 1'b1;
         bus_resp    = base + 64'(i);
         bus_resptag = 13'(i + 'h100);
         if (i == abort_at) return;
         resp_q.push_back('{c, base + 64'(i), 13'(i + 'h100)});
         done = 1'b0;
         for (int n = 0; n < 100 && !done; n++) begin
            stall      = (i == stall_at) && (n < stall_len);
            c0_respack = (c == 0) ? !stall : 1'b1;
            c1_respack = (c == 1) ? !stall : 1'b1;
            @(negedge clk);
            if (stall) check("respack_stall", bus_respack == 1'b0, bus_respack, 64'h0);
            done = bus_respcyc && bus_respack;
            @(posedge clk);
            #1;
         end
         if (!done) check("resp_timeout", 1'b0, 64'h0, 64'h1);
      end
      bus_respcyc = 1'b0;
      c0_respack  = 1'b0;
      c1_respack  = 1'b0;
      check("idle_after_burst", dut.state_q == ARB_IDLE, dut.state_q, ARB_IDLE);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", outs_zero(), 64'h0, 64'h1);
      check("reset_owner_last", (dut.owner_q == 1'b0) && (dut.last_grant_q == 1'b1),
            {dut.last_grant_q, dut.owner_q}, 64'h2);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Single fetch read: one-cycle grant latency, 8 beats to c0 only.
      drive_client(0, 1'b1, 64'h1000, 13'h0001);
      @(negedge clk);
      check("grant_latency_idle", bus_reqcyc == 1'b0, bus_reqcyc, 64'h0);
      @(posedge clk);
      #1;
      check("grant_latency_req", bus_reqcyc && (bus_req == 64'h1000), bus_req, 64'h1000);
      send_beat(0, 64'h1000, 13'h0001, 0);
      c0_reqcyc = 1'b0;
      serve_resp(0, 64'hA000, -1, 0, -1);

      // Memory write: 9 beats with reqack gaps, never touching c0 or RESP.
      in_write = 1'b1;
      for (int i = 0; i < 9; i++) begin
         send_beat(1, (i == 0) ? 64'h2000 : 64'(i), 13'h1005, gaps[i]);
      end
      c1_reqcyc = 1'b0;
      in_write  = 1'b0;
      check("write_no_c0_ack", c0_ack_seen == 1'b0, c0_ack_seen, 64'h0);
      check("write_no_resp", resp_seen == 1'b0, resp_seen, 64'h0);
      check("write_idle", dut.state_q == ARB_IDLE, dut.state_q, ARB_IDLE);

      // Response backpressure: c0 holds respack low 3 cycles on beat 4.
      send_beat(0, 64'h3000, 13'h0002, 1);
      c0_reqcyc = 1'b0;
      serve_resp(0, 64'hD000, 4, 3, -1);

      // Contention from reset: c0 first, then strict alternation.
      do_reset();
      drive_client(0, 1'b1, 64'h4000, 13'h0011);
      drive_client(1, 1'b1, 64'h5000, 13'h0022);
      for (int k = 0; k < 4; k++) begin
         if ((k % 2) == 0) send_beat(0, 64'h4000, 13'h0011, 0);
         else              send_beat(1, 64'h5000, 13'h0022, 0);
         serve_resp(k % 2, 64'hE000 + 64'(k * 16), -1, 0, -1);
      end
      c0_reqcyc = 1'b0;
      c1_reqcyc = 1'b0;
      @(posedge clk);
      #1;
      check("contention_idle", dut.state_q == ARB_IDLE, dut.state_q, ARB_IDLE);

      // Stray response in IDLE.
      bus_respcyc = 1'b1;
      bus_resp    = 64'hDEAD;
      c0_respack  = 1'b1;
      c1_respack  = 1'b1;
      @(negedge clk);
      check("stray_pulse", stray_resp == 1'b1, stray_resp, 64'h1);
      check("stray_no_route", !bus_respack && !c0_respcyc && !c1_respcyc,
            {bus_respack, c1_respcyc, c0_respcyc}, 64'h0);
      @(posedge clk);
      #1;
      bus_respcyc = 1'b0;
      c0_respack  = 1'b0;
      c1_respack  = 1'b0;
      @(negedge clk);
      check("stray_one_cycle", stray_resp == 1'b0, stray_resp, 64'h0);
      @(posedge clk);
      #1;

      // Reset asserted during the 4th response beat.
      send_beat(0, 64'h6000, 13'h0003, 0);
      c0_reqcyc = 1'b0;
      serve_resp(0, 64'hB000, -1, 0, 3);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_outputs", outs_zero(), {bus_respack, c0_respcyc, stray_resp}, 64'h0);
      bus_respcyc = 1'b0;
      c0_respack  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      check("reset_counters", (dut.beat_cnt_q == '0) && (dut.resp_cnt_q == '0)
            && (dut.state_q == ARB_IDLE), {dut.beat_cnt_q, dut.resp_cnt_q}, 64'h0);

      // Fresh c1 read after reset completes a full burst.
      send_beat(1, 64'h7000, 13'h0033, 1);
      c1_reqcyc = 1'b0;
      serve_resp(1, 64'hC000, -1, 0, -1);

      repeat (2) @(posedge clk);
      #1;
      check("queues_drained", (req_q.size() == 0) && (resp_q.size() == 0),
            req_q.size() + resp_q.size(), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
